// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: op codes, access sizes, FSM states
// and small decode helpers used by the stage and the bench.
package mem_pkg;

    localparam logic [3:0] MOP_NONE = 4'd0;
    localparam logic [3:0] MOP_LB   = 4'd1;
    localparam logic [3:0] MOP_LBU  = 4'd2;
    localparam logic [3:0] MOP_LH   = 4'd3;
    localparam logic [3:0] MOP_LHU  = 4'd4;
    localparam logic [3:0] MOP_LW   = 4'd5;
    localparam logic [3:0] MOP_LWU  = 4'd6;
    localparam logic [3:0] MOP_LD   = 4'd7;
    localparam logic [3:0] MOP_SB   = 4'd9;
    localparam logic [3:0] MOP_SH   = 4'd10;
    localparam logic [3:0] MOP_SW   = 4'd11;
    localparam logic [3:0] MOP_SD   = 4'd12;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } state_e;

    function automatic logic mop_is_load(input logic [3:0] op);
        return (op >= MOP_LB) && (op <= MOP_LD);
    endfunction

    function automatic logic mop_is_store(input logic [3:0] op);
        return (op >= MOP_SB) && (op <= MOP_SD);
    endfunction

    function automatic logic [1:0] mop_size(input logic [3:0] op);
        case (op)
            MOP_LH, MOP_LHU, MOP_SH: return SZ_H;
            MOP_LW, MOP_LWU, MOP_SW: return SZ_W;
            MOP_LD, MOP_SD:          return SZ_D;
            default:                 return SZ_B;
        endcase
    endfunction

    // Misaligned access, or a 64-bit-only op on a 32-bit datapath.
    function automatic logic mop_ale(input logic [3:0] op, input logic [2:0] a,
                                     input logic x32);
        logic mis;
        case (mop_size(op))
            SZ_H:    mis = a[0];
            SZ_W:    mis = |a[1:0];
            SZ_D:    mis = |a[2:0];
            default: mis = 1'b0;
        endcase
        if (!(mop_is_load(op) || mop_is_store(op)))
            return 1'b0;
        return mis || (x32 && (op == MOP_LWU || op == MOP_LD || op == MOP_SD));
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load extraction: shifts the addressed element down to bit 0 and sign- or
// zero-extends it to XLEN according to the load op.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]                  op,
    input  logic [$clog2(XLEN/8)-1:0]   off,
    input  logic [XLEN-1:0]             rdata,
    output logic [XLEN-1:0]             data
);

    logic [XLEN-1:0] sh;

    // Accesses are naturally aligned, so a plain byte shift isolates the element.
    assign sh = rdata >> {off, 3'b000};

    always_comb begin
        case (op)
            MOP_LB:  data = XLEN'($signed(sh[7:0]));
            MOP_LBU: data = XLEN'(sh[7:0]);
            MOP_LH:  data = XLEN'($signed(sh[15:0]));
            MOP_LHU: data = XLEN'(sh[15:0]);
            MOP_LW:  data = XLEN'($signed(sh[31:0]));
            MOP_LWU: data = XLEN'(sh[31:0]);
            default: data = sh;
        endcase
    end

endmodule

// File: rtl/mem_stage_v2.sv
// MEM pipeline stage: issues split-transaction data-memory requests, aligns
// loads, traps misaligned accesses and drains responses orphaned by a flush.
module mem_stage_v2
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ex_valid,
    output logic                mem_allowin,
    input  logic [31:0]         ex_pc,
    input  logic [3:0]          ex_mem_op,
    input  logic                ex_rf_we,
    input  logic [4:0]          ex_rf_waddr,
    input  logic [XLEN-1:0]     ex_result,
    input  logic [XLEN-1:0]     ex_store_data,
    input  logic                flush,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [XLEN/8-1:0]   data_wstrb,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [XLEN-1:0]     data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [XLEN-1:0]     data_rdata,
    output logic                mem_to_wb_valid,
    input  logic                wb_allowin,
    output logic [31:0]         wb_pc,
    output logic                wb_rf_we,
    output logic [4:0]          wb_rf_waddr,
    output logic [XLEN-1:0]     wb_rf_wdata,
    output logic                excp_ale,
    output logic [ADDR_W-1:0]   excp_badv
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef struct packed {
        logic [31:0]     pc;
        logic [3:0]      op;
        logic            rf_we;
        logic [4:0]      rf_waddr;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] sdata;
    } stage_t;

    stage_t          st_q;
    logic            valid;
    state_e          state;
    logic [XLEN-1:0] rdata_q;

    logic            is_ld, is_st, is_mem, ale;
    logic            ready_go, do_load, new_req;
    logic [1:0]      size;
    logic [OFFW-1:0] off;
    logic [NB-1:0]   smask;
    logic [XLEN-1:0] al_in, ld_data;

    assign is_ld  = mop_is_load(st_q.op);
    assign is_st  = mop_is_store(st_q.op);
    assign is_mem = is_ld || is_st;
    assign size   = mop_size(st_q.op);
    assign ale    = mop_ale(st_q.op, st_q.result[2:0], XLEN == 32);
    assign off    = st_q.result[OFFW-1:0];

    assign ready_go = !is_mem || ale || (state == ST_WAIT && data_data_ok)
                    || state == ST_DONE;
    assign mem_allowin = resetn && state != ST_DRAIN
                       && (!valid || (ready_go && wb_allowin));
    // A flush in the same cycle wins over handing the result to WB.
    assign mem_to_wb_valid = valid && ready_go && !flush;
    assign do_load = ex_valid && mem_allowin && !flush;
    assign new_req = (mop_is_load(ex_mem_op) || mop_is_store(ex_mem_op))
                   && !mop_ale(ex_mem_op, ex_result[2:0], XLEN == 32);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            valid   <= 1'b0;
            st_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (mem_allowin)
                valid <= ex_valid;
            if (do_load)
                st_q <= '{pc: ex_pc, op: ex_mem_op, rf_we: ex_rf_we,
                          rf_waddr: ex_rf_waddr, result: ex_result,
                          sdata: ex_store_data};
            if (state == ST_WAIT && data_data_ok)
                rdata_q <= data_rdata;

            case (state)
                ST_IDLE:
                    if (do_load && new_req)
                        state <= ST_REQ;
                ST_REQ:
                    if (flush)
                        state <= data_addr_ok ? ST_DRAIN : ST_IDLE;
                    else if (data_addr_ok)
                        state <= ST_WAIT;
                ST_WAIT:
                    if (data_data_ok) begin
                        if (flush || wb_allowin)
                            state <= (do_load && new_req) ? ST_REQ : ST_IDLE;
                        else
                            state <= ST_DONE;
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                ST_DONE:
                    if (flush || wb_allowin)
                        state <= (do_load && new_req) ? ST_REQ : ST_IDLE;
                // The response still owed to the killed request is swallowed here.
                ST_DRAIN:
                    if (data_data_ok)
                        state <= ST_IDLE;
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

    assign smask = NB'((16'd1 << (5'd1 << size)) - 16'd1);

    assign data_req   = state == ST_REQ;
    assign data_wr    = is_st;
    assign data_size  = size;
    assign data_addr  = ADDR_W'(st_q.result);
    assign data_wstrb = is_st ? (smask << off) : '0;

    always_comb begin
        case (size)
            SZ_B:    data_wdata = {NB{st_q.sdata[7:0]}};
            SZ_H:    data_wdata = {(NB/2){st_q.sdata[15:0]}};
            SZ_W:    data_wdata = {(NB/4){st_q.sdata[31:0]}};
            default: data_wdata = st_q.sdata;
        endcase
    end

    // In DONE the bus no longer holds the response, so use the latched copy.
    assign al_in = (state == ST_DONE) ? rdata_q : data_rdata;

    mem_load_align #(.XLEN(XLEN)) u_align (
        .op    (st_q.op),
        .off   (off),
        .rdata (al_in),
        .data  (ld_data)
    );

    assign wb_pc       = st_q.pc;
    assign wb_rf_we    = st_q.rf_we && !is_st && !ale;
    assign wb_rf_waddr = st_q.rf_waddr;
    assign wb_rf_wdata = is_ld ? ld_data : st_q.result;
    assign excp_ale    = valid && ale;
    assign excp_badv   = excp_ale ? ADDR_W'(st_q.result) : '0;

endmodule
